// File: rtl/root_hub_pkg.sv
`timescale 1ns/1ps
// root_hub_pkg
//   Shared constants and helpers for the root-hub message router.
//   - LOCAL_PORT     : index of the root controller port
//   - BROADCAST_DEST : all-ones destination; truncate to the field width in use
//   - dest_field()   : extracts the destination field from the top of a message
//   - rr_pick()      : one-hot round-robin grant starting at a given index
//   The helpers work on maximum-width vectors so they can serve any module
//   parameterisation up to MAX_PORTS ports and MAX_MSG_W-bit messages.
package root_hub_pkg;

    localparam int LOCAL_PORT = 0;
    localparam int MAX_PORTS  = 32;
    localparam int MAX_MSG_W  = 512;
    localparam int MAX_DEST_W = 32;

    localparam logic [MAX_DEST_W-1:0] BROADCAST_DEST = '1;

    // Destination field occupies msg[msg_w-1 -: dest_w].
    function automatic logic [MAX_DEST_W-1:0] dest_field(
        input logic [MAX_MSG_W-1:0] msg,
        input int                   msg_w,
        input int                   dest_w
    );
        logic [MAX_DEST_W-1:0] d;
        d = '0;
        for (int i = 0; i < MAX_DEST_W; i++) begin
            if (i < dest_w) d[i] = msg[msg_w - dest_w + i];
        end
        return d;
    endfunction

    // First requester found scanning start, start+1, ... modulo n.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input int                   start,
        input int                   n
    );
        logic [MAX_PORTS-1:0] g;
        logic                 found;
        int                   idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (k < n) begin
                idx = (start + k) % n;
                if (!found && req[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/hub_input_fifo.sv
`timescale 1ns/1ps
// hub_input_fifo
//   Synchronous FIFO with first-word-fall-through head and registered
//   full/empty flags. One instance buffers each router input.
//   Ports:
//     clk    : clock
//     reset  : synchronous active-low reset (empties the FIFO)
//     push   : write din this cycle (ignored when full)
//     din    : write data
//     pop    : discard the head entry this cycle (ignored when empty)
//     head   : oldest entry, valid whenever empty==0
//     full   : registered, DEPTH entries held
//     empty  : registered, no entries held
module hub_input_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    assign head       = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone decide which
    // entries are meaningful, so the array maps onto plain RAM/registers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // NOTE: all state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/root_hub_router.sv
`timescale 1ns/1ps
// root_hub_router
//   N-port message router for the root FPGA of the decoder tree. Port 0 is
//   the local root-controller port, ports 1..NUM_FPGAS-1 are child links.
//   Every input is buffered in a FIFO; the head is decoded into unicast,
//   broadcast (all ports but the source) or drop. Each output has its own
//   round-robin arbiter feeding a registered valid/ready output stage.
//   Ports:
//     clk        : clock
//     reset      : synchronous active-low reset
//     rx_data    : input messages, port p at [p*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//     rx_valid   : per-port input valid
//     rx_ready   : per-port input ready (FIFO not full, low during reset)
//     tx_data    : output messages, same packing as rx_data
//     tx_valid   : per-port output valid
//     tx_ready   : per-port output ready
//     drop_count : saturating count of dropped messages
//     busy       : any FIFO holds data or any output is valid
module root_hub_router
    import root_hub_pkg::*;
#(
    parameter int NUM_FPGAS     = 5,
    parameter int CHANNEL_WIDTH = 64,
    parameter int DEST_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [CHANNEL_WIDTH*NUM_FPGAS-1:0] rx_data,
    input  logic [NUM_FPGAS-1:0]               rx_valid,
    output logic [NUM_FPGAS-1:0]               rx_ready,
    output logic [CHANNEL_WIDTH*NUM_FPGAS-1:0] tx_data,
    output logic [NUM_FPGAS-1:0]               tx_valid,
    input  logic [NUM_FPGAS-1:0]               tx_ready,
    output logic [CNT_WIDTH-1:0]               drop_count,
    output logic                               busy
);
    localparam int PTR_W = (NUM_FPGAS > 1) ? $clog2(NUM_FPGAS) : 1;
    localparam logic [DEST_WIDTH-1:0] BCAST = DEST_WIDTH'(BROADCAST_DEST);

    logic [NUM_FPGAS-1:0]     full;
    logic [NUM_FPGAS-1:0]     empty;
    logic [NUM_FPGAS-1:0]     push;
    logic [NUM_FPGAS-1:0]     pop;
    logic [NUM_FPGAS-1:0]     drop;
    logic [NUM_FPGAS-1:0]     out_free;
    logic [CHANNEL_WIDTH-1:0] head      [NUM_FPGAS];
    logic [DEST_WIDTH-1:0]    dest      [NUM_FPGAS];
    // Indexed by input: set of outputs the current head must reach.
    logic [NUM_FPGAS-1:0]     target    [NUM_FPGAS];
    logic [NUM_FPGAS-1:0]     sent      [NUM_FPGAS];
    logic [NUM_FPGAS-1:0]     sent_next [NUM_FPGAS];
    logic [NUM_FPGAS-1:0]     gnt_in    [NUM_FPGAS];
    // Indexed by output: requesting / granted inputs.
    logic [NUM_FPGAS-1:0]     req       [NUM_FPGAS];
    logic [NUM_FPGAS-1:0]     gnt       [NUM_FPGAS];
    logic [PTR_W-1:0]         ptr       [NUM_FPGAS];
    logic [PTR_W-1:0]         ptr_next  [NUM_FPGAS];
    logic [CHANNEL_WIDTH-1:0] sel_data  [NUM_FPGAS];
    logic [CNT_WIDTH:0]       drop_sum;
    logic [CNT_WIDTH-1:0]     drop_count_next;

    // Gating with reset keeps inputs from handshaking while the FIFOs clear.
    assign rx_ready = {NUM_FPGAS{reset}} & ~full;
    assign push     = rx_valid & rx_ready;
    assign busy     = !(&empty) || (|tx_valid);

    for (genvar p = 0; p < NUM_FPGAS; p++) begin : g_in
        hub_input_fifo #(
            .WIDTH (CHANNEL_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[p]),
            .din   (rx_data[p*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
            .pop   (pop[p]),
            .head  (head[p]),
            .full  (full[p]),
            .empty (empty[p])
        );
    end

    // Head decode. An empty target set on a present head means drop; this
    // covers out-of-range destinations and messages addressed to their source.
    always_comb begin
        for (int p = 0; p < NUM_FPGAS; p++) begin
            // NOTE: every combinational output gets a default before any
            // conditional update so no path leaves it unassigned (no latch).
            dest[p]   = DEST_WIDTH'(dest_field(MAX_MSG_W'(head[p]), CHANNEL_WIDTH, DEST_WIDTH));
            target[p] = '0;
            if (!empty[p]) begin
                if (dest[p] == BCAST) begin
                    target[p]    = '1;
                    target[p][p] = 1'b0;
                end else begin
                    for (int o = 0; o < NUM_FPGAS; o++) begin
                        if (int'(dest[p]) == o && o != p) target[p][o] = 1'b1;
                    end
                end
            end
            drop[p] = !empty[p] && (target[p] == '0);
        end
    end

    // Per-output round robin. An output only grants when its register can
    // load this cycle, so a grant always equals a delivery.
    always_comb begin
        for (int o = 0; o < NUM_FPGAS; o++) begin
            req[o] = '0;
            for (int i = 0; i < NUM_FPGAS; i++) begin
                req[o][i] = target[i][o] && !sent[i][o];
            end
            out_free[o] = !tx_valid[o] || tx_ready[o];
            gnt[o]      = out_free[o]
                        ? NUM_FPGAS'(rr_pick(MAX_PORTS'(req[o]), int'(ptr[o]), NUM_FPGAS))
                        : '0;
            ptr_next[o] = ptr[o];
            sel_data[o] = '0;
            for (int i = 0; i < NUM_FPGAS; i++) begin
                if (gnt[o][i]) begin
                    ptr_next[o] = PTR_W'((i + 1) % NUM_FPGAS);
                    sel_data[o] = head[i];
                end
            end
        end

        // A head retires once every target output has taken it, counting
        // grants made this cycle; drops retire immediately.
        for (int p = 0; p < NUM_FPGAS; p++) begin
            gnt_in[p] = '0;
            for (int o = 0; o < NUM_FPGAS; o++) begin
                gnt_in[p][o] = gnt[o][p];
            end
            pop[p]       = !empty[p] && ((target[p] & ~(sent[p] | gnt_in[p])) == '0);
            sent_next[p] = pop[p] ? '0 : (sent[p] | gnt_in[p]);
        end
    end

    // Several inputs may drop in the same cycle; add them all, then saturate.
    always_comb begin
        drop_sum = {1'b0, drop_count};
        for (int p = 0; p < NUM_FPGAS; p++) begin
            drop_sum = drop_sum + (CNT_WIDTH+1)'(drop[p]);
        end
        drop_count_next = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int o = 0; o < NUM_FPGAS; o++) begin
                ptr[o]  <= '0;
                sent[o] <= '0;
            end
            tx_valid   <= '0;
            tx_data    <= '0;
            drop_count <= '0;
        end else begin
            for (int o = 0; o < NUM_FPGAS; o++) begin
                ptr[o]  <= ptr_next[o];
                sent[o] <= sent_next[o];
                if (gnt[o] != '0) begin
                    tx_data[o*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= sel_data[o];
                    tx_valid[o] <= 1'b1;
                end else if (tx_ready[o]) begin
                    tx_valid[o] <= 1'b0;
                end
            end
            drop_count <= drop_count_next;
        end
    end

endmodule
